cluster_clock_gate_ctrl: RTL and testbench

// - Sequencer for the cluster clock gate: decides when the cluster clock is stopped and restarted.
// - Sits in the SoC domain on the free-running clock; clk_en_o drives the gate cell's enable (E).
// - Flow: sleep request -> drain until cluster idle -> gate -> wake on event -> settle -> ack.
// - Also counts gated cycles for power statistics.

---
 rtl/cluster_cg_pkg.sv | 27 ++
 rtl/cluster_cg_cnt.sv | 45 ++++
 rtl/cluster_clock_gate_ctrl.sv | 144 ++++++++++++++
 tb/tb_cluster_clock_gate_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cluster_cg_pkg.sv
// ----------------------------------------------------------------------------
// cluster_cg_pkg : shared types and helpers for the cluster clock-gate sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cluster_cg_pkg;

   typedef enum logic [1:0] {
      CG_RUN   = 2'd0,
      CG_DRAIN = 2'd1,
      CG_GATED = 2'd2,
      CG_WAKE  = 2'd3
   } cg_state_e;

   // The shared down-counter must hold the larger of the two reload values.
   function automatic int cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cluster_cg_cnt.sv
// ----------------------------------------------------------------------------
// cluster_cg_cnt : loadable down-counter shared by the DRAIN and WAKE states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cluster_cg_cnt #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/cluster_clock_gate_ctrl.sv
// ----------------------------------------------------------------------------
// cluster_clock_gate_ctrl : sleep/wake sequencer driving the cluster clock gate
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cluster_clock_gate_ctrl
   import cluster_cg_pkg::*;
#(
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_DELAY  = 4,
   parameter int STAT_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              test_en_i,
   input  logic              sleep_req_i,
   input  logic              busy_i,
   input  logic              wake_evt_i,
   input  logic              stat_clr_i,
   output logic              clk_en_o,
   output logic              sleep_ack_o,
   output logic              wake_ack_o,
   output logic              abort_o,
   output logic [STAT_W-1:0] gated_cnt_o
);

   localparam int               CNT_W   = cnt_width(IDLE_CYCLES, WAKE_DELAY);
   localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DELAY - 1);

   cg_state_e         state_q, state_d;
   logic              armed_q, armed_d;
   logic              clk_en_q, sleep_ack_q, wake_ack_q, abort_q;
   logic              wake_ack_d, abort_d;
   logic [STAT_W-1:0] gated_cnt_q, gated_cnt_d;

   logic              cnt_clr, cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt_val;

   cluster_cg_cnt #(.W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q | ~sleep_req_i;
      cnt_clr    = 1'b0;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      cnt_dec    = 1'b0;
      wake_ack_d = 1'b0;
      abort_d    = 1'b0;
      if (test_en_i) begin
         state_d = CG_RUN;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            CG_RUN: begin
               if (sleep_req_i && armed_q) begin
                  state_d  = CG_DRAIN;
                  armed_d  = 1'b0;
                  cnt_load = 1'b1;
                  cnt_val  = IDLE_LD;
               end
            end
            CG_DRAIN: begin
               if (wake_evt_i || !sleep_req_i) begin
                  state_d = CG_RUN;
                  abort_d = 1'b1;
               end else if (busy_i) begin
                  cnt_load = 1'b1;
                  cnt_val  = IDLE_LD;
               end else if (cnt_zero) begin
                  state_d = CG_GATED;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            CG_GATED: begin
               if (wake_evt_i || !sleep_req_i) begin
                  state_d  = CG_WAKE;
                  cnt_load = 1'b1;
                  cnt_val  = WAKE_LD;
               end
            end
            CG_WAKE: begin
               if (cnt_zero) begin
                  state_d    = CG_RUN;
                  wake_ack_d = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            default: state_d = CG_RUN;
         endcase
      end
   end

   // Clear has priority over the per-cycle increment; the count saturates.
   always_comb begin
      gated_cnt_d = gated_cnt_q;
      if (stat_clr_i) begin
         gated_cnt_d = '0;
      end else if ((state_q == CG_GATED) && (gated_cnt_q != {STAT_W{1'b1}})) begin
         gated_cnt_d = gated_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= CG_RUN;
         armed_q     <= 1'b1;
         clk_en_q    <= 1'b1;
         sleep_ack_q <= 1'b0;
         wake_ack_q  <= 1'b0;
         abort_q     <= 1'b0;
         gated_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         clk_en_q    <= (state_d != CG_GATED);
         sleep_ack_q <= (state_d == CG_GATED);
         wake_ack_q  <= wake_ack_d;
         abort_q     <= abort_d;
         gated_cnt_q <= gated_cnt_d;
      end
   end

   assign clk_en_o    = clk_en_q;
   assign sleep_ack_o = sleep_ack_q;
   assign wake_ack_o  = wake_ack_q;
   assign abort_o     = abort_q;
   assign gated_cnt_o = gated_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cluster_clock_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cluster_clock_gate_ctrl : directed self-checking bench for the clock-gate sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cluster_clock_gate_ctrl;

   localparam int STAT_W = 4;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              test_en_i = 1'b0;
   logic              sleep_req_i = 1'b0;
   logic              busy_i = 1'b0;
   logic              wake_evt_i = 1'b0;
   logic              stat_clr_i = 1'b0;
   logic              clk_en_o;
   logic              sleep_ack_o;
   logic              wake_ack_o;
   logic              abort_o;
   logic [STAT_W-1:0] gated_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   cluster_clock_gate_ctrl #(
      .IDLE_CYCLES (8),
      .WAKE_DELAY  (4),
      .STAT_W      (STAT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .test_en_i   (test_en_i),
      .sleep_req_i (sleep_req_i),
      .busy_i      (busy_i),
      .wake_evt_i  (wake_evt_i),
      .stat_clr_i  (stat_clr_i),
      .clk_en_o    (clk_en_o),
      .sleep_ack_o (sleep_ack_o),
      .wake_ack_o  (wake_ack_o),
      .abort_o     (abort_o),
      .gated_cnt_o (gated_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_clk_en"},    32'(clk_en_o),    32'd1);
      chk({tag, "_sleep_ack"}, 32'(sleep_ack_o), 32'd0);
      chk({tag, "_wake_ack"},  32'(wake_ack_o),  32'd0);
      chk({tag, "_abort"},     32'(abort_o),     32'd0);
      chk({tag, "_gated_cnt"}, 32'(gated_cnt_o), 32'd0);
   endtask

   initial begin
      tick(2);
      rst_i = 1'b0;
      chk_reset("reset");

      // Basic sleep: DRAIN after the first edge, eight idle DRAIN cycles, then GATED
      sleep_req_i = 1'b1;
      tick(1);
      chk("drain_entry_clk_en", 32'(clk_en_o), 32'd1);
      tick(7);
      chk("drain_last_clk_en", 32'(clk_en_o), 32'd1);
      chk("drain_last_sleep_ack", 32'(sleep_ack_o), 32'd0);
      tick(1);
      chk("gated_clk_en", 32'(clk_en_o), 32'd0);
      chk("gated_sleep_ack", 32'(sleep_ack_o), 32'd1);
      chk("gated_cnt_first", 32'(gated_cnt_o), 32'd0);
      tick(1);
      chk("gated_cnt_inc1", 32'(gated_cnt_o), 32'd1);
      tick(1);
      chk("gated_cnt_inc2", 32'(gated_cnt_o), 32'd2);

      // Wake event at t: clock back at t+1, ack pulse at t+5
      wake_evt_i = 1'b1;
      tick(1);
      wake_evt_i = 1'b0;
      chk("wake_t1_clk_en", 32'(clk_en_o), 32'd1);
      chk("wake_t1_sleep_ack", 32'(sleep_ack_o), 32'd0);
      chk("wake_t1_gated_cnt", 32'(gated_cnt_o), 32'd3);
      tick(3);
      chk("wake_t4_ack", 32'(wake_ack_o), 32'd0);
      tick(1);
      chk("wake_t5_ack", 32'(wake_ack_o), 32'd1);
      tick(1);
      chk("wake_t6_ack", 32'(wake_ack_o), 32'd0);

      // Request still held after wake: no re-entry
      tick(12);
      chk("held_req_sleep_ack", 32'(sleep_ack_o), 32'd0);
      chk("held_req_clk_en", 32'(clk_en_o), 32'd1);

      // Busy reload: pulse five cycles into DRAIN delays gating by the full idle window
      sleep_req_i = 1'b0;
      tick(1);
      sleep_req_i = 1'b1;
      tick(1);
      tick(4);
      busy_i = 1'b1;
      tick(1);
      busy_i = 1'b0;
      chk("busy_abort", 32'(abort_o), 32'd0);
      tick(7);
      chk("busy_d13_clk_en", 32'(clk_en_o), 32'd1);
      chk("busy_d13_abort", 32'(abort_o), 32'd0);
      tick(1);
      chk("busy_gated_clk_en", 32'(clk_en_o), 32'd0);

      // Stats clear against a simultaneous increment
      tick(1);
      chk("stat_pre_clr", 32'(gated_cnt_o), 32'd4);
      stat_clr_i = 1'b1;
      tick(1);
      stat_clr_i = 1'b0;
      chk("stat_clr_wins", 32'(gated_cnt_o), 32'd0);
      tick(1);
      chk("stat_after_clr", 32'(gated_cnt_o), 32'd1);

      // Test mode from GATED
      test_en_i = 1'b1;
      tick(1);
      chk("test_clk_en", 32'(clk_en_o), 32'd1);
      chk("test_sleep_ack", 32'(sleep_ack_o), 32'd0);
      chk("test_wake_ack", 32'(wake_ack_o), 32'd0);
      chk("test_abort", 32'(abort_o), 32'd0);
      sleep_req_i = 1'b0;
      tick(1);
      sleep_req_i = 1'b1;
      tick(12);
      chk("test_req_ignored_clk_en", 32'(clk_en_o), 32'd1);
      chk("test_req_ignored_sleep_ack", 32'(sleep_ack_o), 32'd0);
      chk("test_wake_ack_later", 32'(wake_ack_o), 32'd0);
      sleep_req_i = 1'b0;
      tick(1);
      test_en_i = 1'b0;
      tick(1);

      // Abort from DRAIN
      sleep_req_i = 1'b1;
      tick(3);
      wake_evt_i = 1'b1;
      tick(1);
      wake_evt_i = 1'b0;
      chk("abort_pulse", 32'(abort_o), 32'd1);
      chk("abort_clk_en", 32'(clk_en_o), 32'd1);
      tick(1);
      chk("abort_pulse_end", 32'(abort_o), 32'd0);
      tick(12);
      chk("abort_no_reentry", 32'(sleep_ack_o), 32'd0);

      // Saturation of the gated-cycle counter
      sleep_req_i = 1'b0;
      tick(1);
      sleep_req_i = 1'b1;
      stat_clr_i = 1'b1;
      tick(1);
      stat_clr_i = 1'b0;
      tick(8);
      chk("sat_gated", 32'(sleep_ack_o), 32'd1);
      chk("sat_start", 32'(gated_cnt_o), 32'd0);
      tick(14);
      chk("sat_14", 32'(gated_cnt_o), 32'd14);
      tick(1);
      chk("sat_15", 32'(gated_cnt_o), 32'd15);
      tick(5);
      chk("sat_hold", 32'(gated_cnt_o), 32'd15);

      // Reset while gated
      rst_i = 1'b1;
      tick(1);
      chk_reset("rst_gated");
      rst_i = 1'b0;
      sleep_req_i = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
